// File: rtl/barrel_rotator_pkg.sv
// Package for the pipelined barrel rotator.
// Holds the operation-mode encodings and the result-counter width
// shared by the rotator data path and its consumers.
package barrel_rotator_pkg;

    // Operation modes carried on in_mode
    localparam logic [1:0] MODE_ROL     = 2'b00;
    localparam logic [1:0] MODE_ROR     = 2'b01;
    localparam logic [1:0] MODE_REV     = 2'b10;
    localparam logic [1:0] MODE_REV_ROL = 2'b11;

    // Width of the accepted-result counter (BRP_TXN_COUNT_EN builds)
    localparam int TXN_CNT_W = 16;

endpackage

// File: rtl/barrel_rotator_pipe_bit_reverse.sv
// bit_reverse_param: purely combinational WIDTH-bit reversal.
//   data : input word
//   rev  : reversed word, rev[i] = data[WIDTH-1-i]
// Used by the normalise stage of barrel_rotator_pipe; reusable elsewhere.
module bit_reverse_param #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] rev
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign rev[i] = data[WIDTH-1-i];
    end

endmodule

// File: rtl/barrel_rotator_pipe.sv
// barrel_rotator_pipe: two-stage pipelined rotator with valid/ready on
// both sides.
//   Stage 1 (normalise): optional bit reversal of the operand and
//   conversion of the mode/shamt pair into a single rotate-left amount.
//   Stage 2 (rotate): log2(WIDTH) mux layers performing rotate-left.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data/in_shamt/in_mode  operand, rotate amount, mode (see package)
//   out_valid/out_ready   output handshake
//   out_data              result
//   txn_count             output-transfer counter, present only when the
//                         macro BRP_TXN_COUNT_EN is defined
module barrel_rotator_pipe
    import barrel_rotator_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
`ifdef BRP_TXN_COUNT_EN
    ,
    output logic [TXN_CNT_W-1:0] txn_count
`endif
);

    // ------------------------------------------------------------------
    // Handshake / stage advance
    // ------------------------------------------------------------------
    logic s1_valid, s2_valid;
    logic s1_load, s2_load, in_fire;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    // No skid buffer: readiness ripples combinationally from out_ready.
    assign in_ready  = s1_load;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    // ------------------------------------------------------------------
    // Stage 1: normalise
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   rev_data;
    logic [WIDTH-1:0]   d1_next, d1;
    logic [SHAMT_W-1:0] a1_next, a1;

    bit_reverse_param #(.WIDTH(WIDTH)) u_rev (
        .data (in_data),
        .rev  (rev_data)
    );

    always_comb begin
        d1_next = (in_mode == MODE_REV || in_mode == MODE_REV_ROL) ? rev_data : in_data;
        a1_next = in_shamt;
        case (in_mode)
            // WIDTH is a power of two, so (WIDTH - shamt) mod WIDTH is just
            // the SHAMT_W-bit two's complement; shamt 0 wraps to 0.
            MODE_ROR: a1_next = SHAMT_W'(0) - in_shamt;
            MODE_REV: a1_next = '0;
            default:  a1_next = in_shamt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            d1       <= '0;
            a1       <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            // Operands only captured on a real transfer, so idle-cycle
            // input values never reach the data registers.
            if (in_valid) begin
                d1 <= d1_next;
                a1 <= a1_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: rotate-left by a1, one mux layer per shamt bit
    // ------------------------------------------------------------------
    logic [SHAMT_W:0][WIDTH-1:0] layer;

    assign layer[0] = d1;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_rot
        localparam int SH = 1 << k;
        assign layer[k+1] = a1[k] ? {layer[k][WIDTH-SH-1:0], layer[k][WIDTH-1:WIDTH-SH]}
                                  : layer[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= layer[SHAMT_W];
            end
        end
    end

`ifdef BRP_TXN_COUNT_EN
    // ------------------------------------------------------------------
    // Output-transfer counter, wraps naturally at 2^TXN_CNT_W
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (s2_valid && out_ready) begin
            txn_count <= txn_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_barrel_rotator_pipe.sv
// Self-checking bench for barrel_rotator_pipe (WIDTH = 8).
// Directed mode cases, backpressure, streaming against a queue-based
// reference model, and reset mid-flight. Counter checks are included
// when BRP_TXN_COUNT_EN is defined.
module tb_barrel_rotator_pipe;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_shamt;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
`ifdef BRP_TXN_COUNT_EN
    logic [15:0]   txn_count;
`endif

    int checks = 0;
    int errs   = 0;

    logic [W-1:0] q[$];
    int n_in  = 0;
    int n_out = 0;
    logic hold_pend = 1'b0;

    always #5 clk = ~clk;

    barrel_rotator_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BRP_TXN_COUNT_EN
        , .txn_count (txn_count)
`endif
    );

    // Reference: reverse if mode[1], then rotate left by the effective amount
    function automatic logic [W-1:0] ref_rot(input logic [W-1:0] d, input int s,
                                             input logic [1:0] m);
        logic [W-1:0] v, r;
        int amt;
        v = d;
        if (m[1]) for (int i = 0; i < W; i++) v[i] = d[W-1-i];
        case (m)
            2'd0:    amt = s;
            2'd1:    amt = (W - s) % W;
            2'd2:    amt = 0;
            default: amt = s;
        endcase
        r = '0;
        for (int i = 0; i < W; i++) r[(i + amt) % W] = v[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with model tracking. Entered and left at posedge+1.
    task automatic tick();
        #2;
        if (hold_pend) check("hold_valid", {31'd0, out_valid}, 32'd1);
        if (out_valid) begin
            if (q.size() > 0) check("stream_data", {24'd0, out_data}, {24'd0, q[0]});
            if (out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                n_out++;
            end
        end
        hold_pend = out_valid && !out_ready;
        if (in_valid && in_ready) begin
            q.push_back(ref_rot(in_data, int'(in_shamt), in_mode));
            n_in++;
        end
        @(posedge clk); #1;
    endtask

    // Single word through an empty pipe, latency checked explicitly
    task automatic directed(input string tag, input logic [W-1:0] d, input logic [SW-1:0] s,
                            input logic [1:0] m, input logic [W-1:0] exp);
        in_data = d; in_shamt = s; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = W'($urandom); in_shamt = SW'($urandom);
        check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_lat2"}, {31'd0, out_valid}, 32'd1);
        check(tag, {24'd0, out_data}, {24'd0, exp});
        @(posedge clk); #1;
        check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, cyc;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0;
        out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, out_data}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
`ifdef BRP_TXN_COUNT_EN
        check("rst_txn_count", {16'd0, txn_count}, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed modes
        directed("rol_81_1",    8'h81, 3'd1, 2'b00, 8'h03);
        directed("rol_f0_4",    8'hF0, 3'd4, 2'b00, 8'h0F);
        directed("ror_01_1",    8'h01, 3'd1, 2'b01, 8'h80);
        directed("ror_a5_0",    8'hA5, 3'd0, 2'b01, 8'hA5);
        directed("ror_81_3",    8'h81, 3'd3, 2'b01, 8'h30);
        directed("rev_01_7",    8'h01, 3'd7, 2'b10, 8'h80);
        directed("revrol_03_2", 8'h03, 3'd2, 2'b11, 8'h03);
        directed("revrol_01_3", 8'h01, 3'd3, 2'b11, 8'h04);

        // Backpressure: two accepts fill the pipe, then in_ready drops
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_shamt = '0;
        in_data = 8'h11; @(posedge clk); #1;
        in_data = 8'h22; #1;
        check("bp_rdy_second", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_data = 8'h33;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("bp_hold_valid",   {31'd0, out_valid}, 32'd1);
            check("bp_hold_data",    {24'd0, out_data}, 32'h11);
            @(posedge clk); #1;
        end
        // Release: 0x33 enters the same cycle 0x11 leaves
        out_ready = 1'b1; #1;
        check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_out_22", {24'd0, out_data}, 32'h22);
        check("bp_v_22",   {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        check("bp_out_33", {24'd0, out_data}, 32'h33);
        check("bp_v_33",   {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        check("bp_empty",  {31'd0, out_valid}, 32'd0);

        // Full throughput with out_ready held high
        q.delete(); n_in = 0; n_out = 0; hold_pend = 1'b0;
        base = n_in;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = W'($urandom); in_shamt = SW'($urandom); in_mode = 2'($urandom);
            tick();
        end
        check("thru_accepts", n_in - base, 32'd16);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("thru_drained", q.size(), 32'd0);

        // Random stream with random backpressure
        cyc = 0; base = n_in;
        while ((n_in - base) < 256 && cyc < 4000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom); in_shamt = SW'($urandom); in_mode = 2'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            cyc++;
        end
        check("rand_sent", n_in - base, 32'd256);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        check("rand_drained", q.size(), 32'd0);
        check("rand_io_count", n_out, n_in);

        // Reset mid-flight with both stages full
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A; in_mode = 2'b00;
        tick(); tick();
        #2;
        rst_n = 1'b0; #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data",  {24'd0, out_data}, 32'd0);
        q.delete(); n_in = 0; n_out = 0; hold_pend = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("postrst_no_stale", {31'd0, out_valid}, 32'd0);
        end
`ifdef BRP_TXN_COUNT_EN
        check("postrst_txn_count", {16'd0, txn_count}, 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = W'($urandom); in_shamt = SW'($urandom); in_mode = 2'($urandom);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("txn_count_3", {16'd0, txn_count}, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/barrel_rotator_pipe.md
Name: barrel_rotator_pipe

Overview:
- Parametrised, pipelined data-path block for the multi-barrel rotator: bit-reverse generalised to WIDTH bits, plus rotate-left, rotate-right and reverse-then-rotate modes.
- Two register stages with valid/ready handshake on both sides; full throughput, backpressure supported.
- Sits between the operand source and the downstream rotator consumers.

Parameters:
- WIDTH, 8, data width in bits; power of two, >= 2
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  rotate amount
- in_mode  input  2  00 ROL, 01 ROR, 10 REV, 11 REV_ROL
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  result
- txn_count  output  16  accepted-result count (only with BRP_TXN_COUNT_EN)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: s1_valid = 0, s2_valid = 0, so out_valid = 0. out_data = 0, all stage data/shamt registers = 0, txn_count = 0.
- Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - out_valid and out_data hold stable while out_valid && !out_ready.
- Stage advance:
  - s2 loads when !s2_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - in_ready = !s1_valid || (s2 loads); combinational from out_ready, no skid buffer.
- Stage 1 (normalise), registered:
  - d1 = REV or REV_ROL ? bit_reverse(in_data) : in_data; bit_reverse maps out[i] = in[WIDTH-1-i].
  - a1 = ROR ? (WIDTH - in_shamt) mod WIDTH : REV ? 0 : in_shamt. Arithmetic is in SHAMT_W bits, wrap intended.
- Stage 2 (rotate), registered: out_data = rotate-left(d1, a1), i.e. {d1, d1} >> (WIDTH - a1) low WIDTH bits. Implemented as log2 mux layers.
- Latency: exactly 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 word per cycle.
- Boundary conditions:
  - shamt = 0: identity rotate in all modes, including ROR (wrap gives 0).
  - REV ignores in_shamt.
  - Both stages full with out_ready = 0: in_ready = 0, no data lost or duplicated, order preserved.
  - Simultaneous out transfer and in transfer while full: both happen in the same cycle, pipeline stays full.
  - in_data/in_mode/in_shamt ignored when no input transfer.
  - Reset asserted mid-operation: both valids clear immediately (async), in-flight words discarded, out_valid = 0 on the same edge.
- No X on outputs after reset.

Optional Feature:
- Macro: BRP_TXN_COUNT_EN
- Defined:
  - txn_count port exists; increments by 1 on each output transfer; wraps 0xFFFF -> 0x0000.
  - Cleared by rst_n.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package barrel_rotator_pkg:
  - mode localparams MODE_ROL = 2'b00, MODE_ROR = 2'b01, MODE_REV = 2'b10, MODE_REV_ROL = 2'b11.
  - Counter width constant TXN_CNT_W = 16.
- Sub-module bit_reverse_param:
  - parametrised WIDTH, combinational generate loop.
  - Instantiated in stage 1; reusable elsewhere in the rotator.

Test Plan (WIDTH=8):
- ROL: 0x81, shamt 1 -> 0x03 with out_valid two cycles after accept. ROL 0xF0, shamt 4 -> 0x0F.
- ROR: 0x01, shamt 1 -> 0x80. ROR 0xA5, shamt 0 -> 0xA5 (wrap case).
- REV: 0x01, shamt 7 -> 0x80 (shamt ignored). REV_ROL 0x03, shamt 2 -> reverse 0xC0 -> 0x03.
- Backpressure:
  - Hold out_ready = 0 and offer 0x11, 0x22, 0x33 back-to-back -> in_ready drops after 2 accepts; out_data holds 0x11 stable.
  - Release out_ready -> 0x11, 0x22, 0x33 emerge in order; none dropped or duplicated.
- Streaming: 256 random words with out_ready toggling randomly -> scoreboard match against a reference model, throughput of 1 word per cycle when out_ready is held high.
- Reset mid-flight: assert rst_n low with both stages valid -> out_valid = 0 immediately, no stale output after deassert. With BRP_TXN_COUNT_EN, txn_count = 0; 3 output transfers then read 3.
